mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
//   Multi-cycle control FSM for the RV32I core. Sequences fetch, decode,
//   execute, memory and writeback around the decoder, ALU, register file and
//   memories. Consumes the decoder's one-hot class flags and drives all
//   datapath write-enables, mux selects and memory handshakes.
// PARAMETERS
//   TIMEOUT  16  max cycles to wait for imem_ack/dmem_ack before trapping (>=2)
//   CNT_W    32  width of instret counter
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   is_r,is_imm,is_l,is_s,is_b,is_j,is_jalr,is_lui,is_auipc,is_csr  in 1 each  decoder class flags
//   func3        in   3      instruction func3
//   rd           in   5      destination register index
//   branch_taken in   1      ALU compare result, valid in EXEC
//   imem_req     out  1      instruction fetch request
//   imem_ack     in   1      fetch data valid
//   dmem_req     out  1      data memory request
//   dmem_we      out  1      data memory write (store)
//   dmem_ack     in   1      data access complete
//   ir_we        out  1      latch instruction register
//   pc_we        out  1      update PC
//   pc_sel       out  2      0 pc+4, 1 pc+imm (branch/jal), 2 (rs1+imm)&~1 (jalr)
//   alu_a_sel    out  1      0 rs1, 1 pc
//   alu_b_sel    out  1      0 rs2, 1 imm
//   wb_sel       out  2      0 alu, 1 mem, 2 pc+4, 3 imm
//   reg_we       out  1      register file write
//   halted       out  1      sticky trap indicator
//   trap_cause   out  2      0 none, 1 illegal opcode, 2 ecall/ebreak, 3 memory timeout
//   state        out  3      current state encoding (debug)
//   instret      out  CNT_W  retired instruction count
// BEHAVIOUR
// - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Reset -> FETCH;
//   all outputs 0 except imem_req=1 (combinational from FETCH); instret=0.
// - FETCH: imem_req=1 held until imem_ack. ack cycle: ir_we=1, -> DECODE.
// - DECODE: 1 cycle. No class flag set -> TRAP, cause 1. is_csr with
//   func3==0 -> TRAP, cause 2. Otherwise -> EXEC.
// - EXEC: 1 cycle; alu_a_sel=1 for auipc/jal/branch, alu_b_sel=1 unless is_r
//   or is_b. is_l/is_s -> MEM. is_b: not taken -> pc_we=1,pc_sel=0; taken ->
//   pc_we=1,pc_sel=1; increment instret; -> FETCH. All others -> WB.
// - MEM: dmem_req=1, dmem_we=is_s, held until dmem_ack. On ack: load -> WB;
//   store -> pc_we=1,pc_sel=0, instret++, -> FETCH.
// - WB: 1 cycle. reg_we=1 iff rd!=0. wb_sel: load 1, jal/jalr 2, lui 3, else 0.
//   pc_we=1; pc_sel 1 for jal, 2 for jalr, else 0. instret++. -> FETCH.
// - Only one of pc_we/ir_we/reg_we pulses per cycle except WB (reg_we+pc_we).
// - Timeout: wait counter clears on entry to FETCH/MEM and counts each
//   non-ack cycle; reaching TIMEOUT without ack -> TRAP, cause 3, req drops.
//   ack on the same cycle the count reaches TIMEOUT wins (no trap).
// - TRAP: all enables and requests 0, halted=1, trap_cause held; exits only
//   on rst. instret not incremented for trapping instruction.
// - instret wraps modulo 2^CNT_W.
// - rst asserted mid-access: requests drop immediately (async), FSM -> FETCH;
//   late acks after reset while in FETCH are treated as valid fetch acks.
// TESTING
// - add (is_r, rd=5), imem/dmem ack after 1 cycle -> states 0,1,2,4,0;
//   reg_we=1 in WB, wb_sel=0, pc_sel=0, instret 0->1.
// - lw rd=3 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles,
//   dmem_we=0, then WB with wb_sel=1, reg_we=1; sw -> no WB, pc_we in MEM ack.
// - beq taken -> pc_we=1,pc_sel=1 in EXEC, reg_we never 1; jalr rd=0 ->
//   WB pc_sel=2, reg_we=0.
// - Opcode with no flag -> TRAP after DECODE, halted=1, cause=1, no further
//   imem_req; ecall -> cause=2; instret unchanged.
// - imem_ack never asserted, TIMEOUT=16 -> TRAP with cause=3 after 16 cycles;
//   ack at 16th cycle -> normal DECODE.
// - rst pulse during MEM wait -> dmem_req=0 same cycle, state=0, instret=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side, slave = datapath/decoder/memory side.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             is_r, is_imm, is_l, is_s, is_b, is_j, is_jalr;
   logic             is_lui, is_auipc, is_csr;
   logic [2:0]       func3;
   logic [4:0]       rd;
   logic             branch_taken;
   logic             imem_req, imem_ack;
   logic             dmem_req, dmem_we, dmem_ack;
   logic             ir_we, pc_we, reg_we;
   logic [1:0]       pc_sel, wb_sel;
   logic             alu_a_sel, alu_b_sel;
   logic             halted;
   logic [1:0]       trap_cause;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   modport master (
      input  is_r, is_imm, is_l, is_s, is_b, is_j, is_jalr, is_lui, is_auipc, is_csr,
      input  func3, rd, branch_taken, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
      output wb_sel, reg_we, halted, trap_cause, state, instret
   );

   modport slave (
      output is_r, is_imm, is_l, is_s, is_b, is_j, is_jalr, is_lui, is_auipc, is_csr,
      output func3, rd, branch_taken, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
      input  wb_sel, reg_we, halted, trap_cause, state, instret
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/exec/mem/wb
// sequencing, memory handshake timeouts, sticky trap and retire counter.
module mc_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic         clk,
   input  logic         rst,
   mc_ctrl_if.master    bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam int WAIT_W = $clog2(TIMEOUT) + 1;

   logic [2:0]       st, st_nxt;
   logic [1:0]       cause, cause_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] ret_cnt;
   logic             retire;
   logic             any_cls, ecall, mem_op, timeout_hit, ack_now;

   assign any_cls = bus.is_r | bus.is_imm | bus.is_l | bus.is_s | bus.is_b | bus.is_j |
                    bus.is_jalr | bus.is_lui | bus.is_auipc | bus.is_csr;
   assign ecall   = bus.is_csr && (bus.func3 == 3'd0);
   assign mem_op  = bus.is_l | bus.is_s;
   // Last allowed wait cycle: an ack here still wins over the timeout.
   assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign ack_now = (st == S_FETCH) ? bus.imem_ack : bus.dmem_ack;

   // Next-state, trap cause and retire decision.
   always_comb begin
      st_nxt    = st;
      cause_nxt = cause;
      retire    = 1'b0;
      case (st)
         S_FETCH: begin
            if (bus.imem_ack)     st_nxt = S_DECODE;
            else if (timeout_hit) begin st_nxt = S_TRAP; cause_nxt = 2'd3; end
         end
         S_DECODE: begin
            if (!any_cls)   begin st_nxt = S_TRAP; cause_nxt = 2'd1; end
            else if (ecall) begin st_nxt = S_TRAP; cause_nxt = 2'd2; end
            else            st_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (mem_op)        st_nxt = S_MEM;
            else if (bus.is_b) begin st_nxt = S_FETCH; retire = 1'b1; end
            else               st_nxt = S_WB;
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               if (bus.is_s) begin st_nxt = S_FETCH; retire = 1'b1; end
               else          st_nxt = S_WB;
            end else if (timeout_hit) begin
               st_nxt = S_TRAP; cause_nxt = 2'd3;
            end
         end
         S_WB: begin
            st_nxt = S_FETCH;
            retire = 1'b1;
         end
         S_TRAP:  st_nxt = S_TRAP;
         default: st_nxt = S_FETCH;
      endcase
   end

   // Datapath strobes and selects, decoded from the current state.
   always_comb begin
      bus.imem_req  = (st == S_FETCH);
      bus.dmem_req  = 1'b0;
      bus.dmem_we   = 1'b0;
      bus.ir_we     = 1'b0;
      bus.pc_we     = 1'b0;
      bus.pc_sel    = 2'd0;
      bus.alu_a_sel = 1'b0;
      bus.alu_b_sel = 1'b0;
      bus.wb_sel    = 2'd0;
      bus.reg_we    = 1'b0;
      case (st)
         S_FETCH: bus.ir_we = bus.imem_ack && !rst;
         S_EXEC: begin
            bus.alu_a_sel = bus.is_auipc | bus.is_j | bus.is_b;
            bus.alu_b_sel = !(bus.is_r | bus.is_b);
            if (!mem_op && bus.is_b) begin
               bus.pc_we  = 1'b1;
               bus.pc_sel = bus.branch_taken ? 2'd1 : 2'd0;
            end
         end
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = bus.is_s;
            bus.pc_we    = bus.dmem_ack && bus.is_s;
         end
         S_WB: begin
            bus.reg_we = (bus.rd != 5'd0);
            bus.pc_we  = 1'b1;
            if (bus.is_l)                     bus.wb_sel = 2'd1;
            else if (bus.is_j || bus.is_jalr) bus.wb_sel = 2'd2;
            else if (bus.is_lui)              bus.wb_sel = 2'd3;
            if (bus.is_j)                     bus.pc_sel = 2'd1;
            else if (bus.is_jalr)             bus.pc_sel = 2'd2;
         end
         default: ;
      endcase
   end

   assign bus.halted     = (st == S_TRAP);
   assign bus.trap_cause = cause;
   assign bus.state      = st;
   assign bus.instret    = ret_cnt;

   // State, cause, retire counter and handshake wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= S_FETCH;
         cause    <= 2'd0;
         ret_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         st    <= st_nxt;
         cause <= cause_nxt;
         if (retire) ret_cnt <= ret_cnt + 1'b1;
         if ((st == S_FETCH || st == S_MEM) && !ack_now && !timeout_hit)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end
endmodule
